// File: rtl/imem_load_if.sv
// Bundles the UART word-assembler, CPU fetch and instruction-memory signals
// of the instruction-memory load controller.
interface imem_load_if;
  logic        w_ready_rx;
  logic [31:0] instr_data_rx;
  logic [31:0] addr_rx;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        pos_instr_w;
  logic        neg_instr_w;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        cpu_hold_rst;
  logic        load_active;
  logic [15:0] word_cnt;
  logic        err_misaligned;

  modport master (
    output w_ready_rx, instr_data_rx, addr_rx, cpu_req, cpu_addr,
    input  pos_instr_w, neg_instr_w, mem_en, mem_we, mem_addr, mem_wdata,
           cpu_stall, cpu_hold_rst, load_active, word_cnt, err_misaligned
  );

  modport slave (
    input  w_ready_rx, instr_data_rx, addr_rx, cpu_req, cpu_addr,
    output pos_instr_w, neg_instr_w, mem_en, mem_we, mem_addr, mem_wdata,
           cpu_stall, cpu_hold_rst, load_active, word_cnt, err_misaligned
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: while the board switch is up, UART words
// are written into instruction memory with the CPU frozen, then the CPU is released.
module imem_load_ctrl #(
  parameter int RELEASE_CYCLES = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    load_sw,
  imem_load_if.slave bus
);

  localparam int CW = (RELEASE_CYCLES < 1) ? 1 : $clog2(RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] REL_LOAD = CW'(RELEASE_CYCLES);
  localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {RUN, LOAD, WRITE, HOLD} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_chain_reg;
  logic [SYNC_STAGES-1:0] sync_valid_reg;
  logic                   sync_hist_reg;
  logic                   armed_reg;
  logic [31:0]            addr_reg, addr_next;
  logic [31:0]            data_reg, data_next;
  logic [15:0]            cnt_reg, cnt_next;
  logic                   err_reg, err_next;
  logic                   pend_reg, pend_next;
  logic [CW-1:0]          rel_reg, rel_next;

  logic sync_lvl;
  logic sync_rise;
  logic sync_fall;

  logic        pos_w, neg_w, en_w, we_w, stall_w, hold_w, active_w;
  logic [31:0] maddr_w, wdata_w;

  assign sync_lvl  = sync_chain_reg[SYNC_STAGES-1];
  // A rise only counts once a genuine low has been seen since reset, so a
  // switch left high across a reset cannot restart a session.
  assign sync_rise = sync_lvl & ~sync_hist_reg & armed_reg;
  assign sync_fall = ~sync_lvl & sync_hist_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain_reg <= '0;
      sync_valid_reg <= '0;
      sync_hist_reg  <= 1'b0;
      armed_reg      <= 1'b0;
    end else begin
      sync_chain_reg[0] <= load_sw;
      sync_valid_reg[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain_reg[i] <= sync_chain_reg[i-1];
        sync_valid_reg[i] <= sync_valid_reg[i-1];
      end
      sync_hist_reg <= sync_lvl;
      if (sync_valid_reg[SYNC_STAGES-1] && !sync_lvl) begin
        armed_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      addr_reg  <= '0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      pend_reg  <= 1'b0;
      rel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      pend_reg  <= pend_next;
      rel_reg   <= rel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    pend_next  = pend_reg;
    rel_next   = rel_reg;
    pos_w      = 1'b0;
    neg_w      = 1'b0;
    en_w       = 1'b0;
    we_w       = 1'b0;
    maddr_w    = '0;
    wdata_w    = '0;
    stall_w    = 1'b1;
    hold_w     = 1'b1;
    active_w   = 1'b0;

    case (state_reg)
      RUN: begin
        stall_w = 1'b0;
        hold_w  = 1'b0;
        en_w    = bus.cpu_req;
        maddr_w = bus.cpu_addr;
        if (sync_rise) begin
          pos_w      = 1'b1;
          cnt_next   = '0;
          err_next   = 1'b0;
          pend_next  = 1'b0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        active_w = 1'b1;
        // A word arriving together with the end request is written first;
        // the end is remembered and served on the next LOAD cycle.
        if (bus.w_ready_rx) begin
          addr_next  = bus.addr_rx;
          data_next  = bus.instr_data_rx;
          state_next = WRITE;
          if (sync_fall) begin
            pend_next = 1'b1;
          end
        end else if (sync_fall || pend_reg) begin
          neg_w      = 1'b1;
          pend_next  = 1'b0;
          rel_next   = REL_LOAD;
          state_next = HOLD;
        end
      end
      WRITE: begin
        active_w = 1'b1;
        en_w     = 1'b1;
        we_w     = 1'b1;
        maddr_w  = {addr_reg[31:2], 2'b00};
        wdata_w  = data_reg;
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 16'd1;
        end
        if (addr_reg[1:0] != 2'b00) begin
          err_next = 1'b1;
        end
        if (sync_fall) begin
          pend_next = 1'b1;
        end
        state_next = LOAD;
      end
      HOLD: begin
        if (sync_rise) begin
          pos_w      = 1'b1;
          cnt_next   = '0;
          err_next   = 1'b0;
          rel_next   = '0;
          state_next = LOAD;
        end else if (rel_reg <= CW'(1)) begin
          // Last held cycle: the CPU comes out of reset on the next one.
          rel_next   = '0;
          state_next = RUN;
        end else begin
          rel_next = rel_reg - CW'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign bus.pos_instr_w    = pos_w;
  assign bus.neg_instr_w    = neg_w;
  assign bus.mem_en         = en_w;
  assign bus.mem_we         = we_w;
  assign bus.mem_addr       = maddr_w;
  assign bus.mem_wdata      = wdata_w;
  assign bus.cpu_stall      = stall_w;
  assign bus.cpu_hold_rst   = hold_w;
  assign bus.load_active    = active_w;
  assign bus.word_cnt       = cnt_reg;
  assign bus.err_misaligned = err_reg;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: vector tables, directed session
// corner cases and randomized sessions against a session-level model.
module tb_imem_load_ctrl;
  localparam int RELEASE_CYCLES = 4;
  localparam int SYNC_STAGES    = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic        exp_err;
  } wr_vec_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic        exp_en;
    logic [31:0] exp_addr;
  } run_vec_t;

  logic clk = 1'b0;
  logic rst;
  logic load_sw;
  int   checks = 0;
  int   errors = 0;
  int   rise_lat = SYNC_STAGES;
  logic prev_pos = 1'b0;
  logic prev_neg = 1'b0;

  wr_vec_t  wr_tab[5];
  run_vec_t run_tab[4];

  imem_load_if bus();

  imem_load_ctrl #(
    .RELEASE_CYCLES(RELEASE_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_sw(load_sw),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Session pulses must be single-cycle and mutually exclusive.
  always @(negedge clk) begin
    checks++;
    if ((bus.pos_instr_w && bus.neg_instr_w) || (bus.pos_instr_w && prev_pos) ||
        (bus.neg_instr_w && prev_neg)) begin
      errors++;
      $display("FAIL pulse_shape: pos=%b neg=%b prev_pos=%b prev_neg=%b, required single-cycle exclusive pulses",
               bus.pos_instr_w, bus.neg_instr_w, prev_pos, prev_neg);
    end
    prev_pos = bus.pos_instr_w;
    prev_neg = bus.neg_instr_w;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input logic req, input logic [31:0] addr, input logic wr);
    bus.cpu_req       = req;
    bus.cpu_addr      = addr;
    bus.w_ready_rx    = wr;
    bus.addr_rx       = $urandom;
    bus.instr_data_rx = $urandom;
    @(negedge clk);
    chk1("run_mem_en", bus.mem_en, req);
    chk32("run_mem_addr", bus.mem_addr, addr);
    chk1("run_mem_we", bus.mem_we, 1'b0);
    chk1("run_stall", bus.cpu_stall, 1'b0);
    chk1("run_hold_rst", bus.cpu_hold_rst, 1'b0);
    step();
    bus.w_ready_rx = 1'b0;
  endtask

  task automatic enter_load();
    int lat = -1;
    load_sw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.pos_instr_w) begin
        lat = i;
        break;
      end
      step();
    end
    checks++;
    if (lat < SYNC_STAGES || lat > SYNC_STAGES + 1) begin
      errors++;
      $display("FAIL rise_latency: got %0d cycles, required %0d..%0d", lat, SYNC_STAGES, SYNC_STAGES + 1);
    end
    if (lat >= 0) begin
      rise_lat = lat;
      step();
    end
    @(negedge clk);
    chk1("load_stall", bus.cpu_stall, 1'b1);
    chk1("load_hold_rst", bus.cpu_hold_rst, 1'b1);
    chk1("load_active", bus.load_active, 1'b1);
    chk1("load_mem_en", bus.mem_en, 1'b0);
    chk32("load_word_cnt", {16'h0, bus.word_cnt}, 32'h0);
    chk1("load_err_clear", bus.err_misaligned, 1'b0);
    $display("txn enter_load latency=%0d", lat);
    step();
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_addr, input int exp_cnt, input logic exp_err);
    bus.addr_rx       = addr;
    bus.instr_data_rx = data;
    bus.w_ready_rx    = 1'b1;
    @(negedge clk);
    chk1("wr_no_early_we", bus.mem_we, 1'b0);
    chk1("wr_no_neg", bus.neg_instr_w, 1'b0);
    step();
    bus.w_ready_rx    = 1'b0;
    bus.addr_rx       = $urandom;
    bus.instr_data_rx = $urandom;
    @(negedge clk);
    chk1("wr_mem_we", bus.mem_we, 1'b1);
    chk1("wr_mem_en", bus.mem_en, 1'b1);
    chk32("wr_mem_addr", bus.mem_addr, exp_addr);
    chk32("wr_mem_wdata", bus.mem_wdata, data);
    chk1("wr_active", bus.load_active, 1'b1);
    step();
    @(negedge clk);
    chk1("wr_we_single", bus.mem_we, 1'b0);
    chk32("wr_word_cnt", {16'h0, bus.word_cnt}, 32'(exp_cnt));
    chk1("wr_err", bus.err_misaligned, exp_err);
    $display("txn write addr=0x%h data=0x%h cnt=%0d err=%b", addr, data, bus.word_cnt, bus.err_misaligned);
    step();
  endtask

  task automatic wait_neg(output logic found);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.neg_instr_w) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk1("neg_seen", found, 1'b1);
  endtask

  // Starts the cycle after neg_instr_w; counts cycles until the CPU is released.
  task automatic count_release();
    int n = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (!bus.cpu_hold_rst) begin
        n = j;
        break;
      end
      chk1("hold_active_low", bus.load_active, 1'b0);
      chk1("hold_stall", bus.cpu_stall, 1'b1);
      chk1("hold_mem_en", bus.mem_en, 1'b0);
      step();
    end
    chk32("release_cycles", 32'(n), 32'(RELEASE_CYCLES + 1));
    chk1("released_stall", bus.cpu_stall, 1'b0);
    $display("txn release after %0d cycles", n);
    step();
  endtask

  task automatic exit_session(input int exp_cnt, input logic exp_err);
    logic found;
    load_sw = 1'b0;
    wait_neg(found);
    chk32("exit_word_cnt", {16'h0, bus.word_cnt}, 32'(exp_cnt));
    chk1("exit_err", bus.err_misaligned, exp_err);
    step();
    count_release();
  endtask

  // Word arrives off cycles before the synchronised fall (0 = same cycle).
  task automatic coinc(input int off, input logic [31:0] addr, input logic [31:0] data);
    load_sw = 1'b0;
    for (int i = 0; i < rise_lat - off; i++) begin
      @(negedge clk);
      chk1("coinc_pre_neg", bus.neg_instr_w, 1'b0);
      step();
    end
    bus.addr_rx       = addr;
    bus.instr_data_rx = data;
    bus.w_ready_rx    = 1'b1;
    @(negedge clk);
    chk1("coinc_neg_deferred", bus.neg_instr_w, 1'b0);
    step();
    bus.w_ready_rx = 1'b0;
    @(negedge clk);
    chk1("coinc_mem_we", bus.mem_we, 1'b1);
    chk32("coinc_mem_addr", bus.mem_addr, addr);
    chk1("coinc_neg_in_write", bus.neg_instr_w, 1'b0);
    step();
    @(negedge clk);
    chk1("coinc_neg_after_write", bus.neg_instr_w, 1'b1);
    chk1("coinc_we_off", bus.mem_we, 1'b0);
    $display("txn coincident off=%0d addr=0x%h", off, addr);
    step();
    count_release();
  endtask

  initial begin
    logic        found;
    logic [31:0] a, d;
    int          exp_cnt;
    logic        exp_err;
    int          nwords;

    wr_tab[0] = '{32'h0000_0010, 32'h0050_0093, 32'h0000_0010, 1'b0};
    wr_tab[1] = '{32'h0000_0014, 32'h00A0_0113, 32'h0000_0014, 1'b0};
    wr_tab[2] = '{32'h0000_0013, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1};
    wr_tab[3] = '{32'h0000_0020, 32'h1234_5678, 32'h0000_0020, 1'b1};
    wr_tab[4] = '{32'h0000_0102, 32'hCAFE_F00D, 32'h0000_0100, 1'b1};

    run_tab[0] = '{1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040};
    run_tab[1] = '{1'b0, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0080};
    run_tab[2] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC};
    run_tab[3] = '{1'b1, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0003};

    rst = 1'b1;
    load_sw = 1'b0;
    bus.w_ready_rx = 1'b0;
    bus.instr_data_rx = '0;
    bus.addr_rx = '0;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h0000_1234;
    step();
    @(negedge clk);
    chk1("rst_pos", bus.pos_instr_w, 1'b0);
    chk1("rst_neg", bus.neg_instr_w, 1'b0);
    chk1("rst_we", bus.mem_we, 1'b0);
    chk1("rst_mem_en_follows", bus.mem_en, 1'b1);
    chk32("rst_mem_addr_follows", bus.mem_addr, 32'h0000_1234);
    chk32("rst_wdata", bus.mem_wdata, 32'h0);
    chk1("rst_stall", bus.cpu_stall, 1'b0);
    chk1("rst_hold", bus.cpu_hold_rst, 1'b0);
    chk1("rst_active", bus.load_active, 1'b0);
    chk32("rst_word_cnt", {16'h0, bus.word_cnt}, 32'h0);
    chk1("rst_err", bus.err_misaligned, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    for (int i = 0; i < 4; i++) begin
      bus.cpu_req    = run_tab[i].req;
      bus.cpu_addr   = run_tab[i].addr;
      bus.w_ready_rx = run_tab[i].wr;
      @(negedge clk);
      chk1("tab_mem_en", bus.mem_en, run_tab[i].exp_en);
      chk32("tab_mem_addr", bus.mem_addr, run_tab[i].exp_addr);
      chk1("tab_mem_we", bus.mem_we, 1'b0);
      step();
      bus.w_ready_rx = 1'b0;
      @(negedge clk);
      chk1("tab_no_write_after", bus.mem_we, 1'b0);
      chk1("tab_no_load", bus.load_active, 1'b0);
      $display("txn run req=%b addr=0x%h wr=%b en=%b", run_tab[i].req, run_tab[i].addr, run_tab[i].wr, bus.mem_en);
      step();
    end

    enter_load();
    for (int i = 0; i < 5; i++) begin
      write_word(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].exp_addr, i + 1, wr_tab[i].exp_err);
    end

    // Restart from HOLD: sticky error survives until the new pos_instr_w.
    load_sw = 1'b0;
    wait_neg(found);
    chk1("hold_err_sticky", bus.err_misaligned, 1'b1);
    chk32("hold_word_cnt", {16'h0, bus.word_cnt}, 32'd5);
    step();
    load_sw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.pos_instr_w) begin
        found = 1'b1;
        break;
      end
      chk1("hold_not_released", bus.cpu_hold_rst, 1'b1);
      step();
    end
    chk1("hold_rise_pos", found, 1'b1);
    step();
    @(negedge clk);
    chk32("hold_rise_cnt_clr", {16'h0, bus.word_cnt}, 32'h0);
    chk1("hold_rise_err_clr", bus.err_misaligned, 1'b0);
    chk1("hold_rise_active", bus.load_active, 1'b1);
    $display("txn restart from hold found=%b", found);
    step();

    write_word(32'h0000_0200, 32'h0000_0013, 32'h0000_0200, 1, 1'b0);
    coinc(0, 32'h0000_0044, 32'h0010_0073);

    enter_load();
    coinc(1, 32'h0000_0048, 32'h0020_0073);

    enter_load();
    write_word(32'h0000_0300, 32'h1111_2222, 32'h0000_0300, 1, 1'b0);
    rst = 1'b1;
    bus.w_ready_rx = 1'b1;
    bus.addr_rx = 32'h0000_0080;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h0000_0040;
    @(negedge clk);
    chk1("midrst_we", bus.mem_we, 1'b0);
    chk1("midrst_en", bus.mem_en, 1'b1);
    chk32("midrst_addr", bus.mem_addr, 32'h0000_0040);
    chk1("midrst_stall", bus.cpu_stall, 1'b0);
    chk1("midrst_hold", bus.cpu_hold_rst, 1'b0);
    chk1("midrst_active", bus.load_active, 1'b0);
    chk32("midrst_word_cnt", {16'h0, bus.word_cnt}, 32'h0);
    chk1("midrst_neg", bus.neg_instr_w, 1'b0);
    step();
    bus.w_ready_rx = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("postrst_no_pos", bus.pos_instr_w, 1'b0);
      chk1("postrst_no_neg", bus.neg_instr_w, 1'b0);
      chk1("postrst_run", bus.load_active, 1'b0);
      step();
    end
    load_sw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("postrst_fall_ignored", bus.neg_instr_w, 1'b0);
      chk1("postrst_hold", bus.cpu_hold_rst, 1'b0);
      step();
    end
    $display("txn reset mid-session");
    enter_load();
    exit_session(0, 1'b0);

    for (int s = 0; s < 6; s++) begin
      enter_load();
      exp_cnt = 0;
      exp_err = 1'b0;
      nwords = $urandom_range(1, 6);
      for (int w = 0; w < nwords; w++) begin
        a = $urandom & 32'h0000_FFFF;
        d = $urandom;
        exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : exp_cnt;
        exp_err = exp_err | ((a % 4) != 0);
        write_word(a, d, a - (a % 4), exp_cnt, exp_err);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          @(negedge clk);
          chk1("gap_no_we", bus.mem_we, 1'b0);
          chk1("gap_no_neg", bus.neg_instr_w, 1'b0);
          step();
        end
      end
      exit_session(exp_cnt, exp_err);
      for (int r = 0; r < int'($urandom_range(3, 8)); r++) begin
        run_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter RELEASE_CYCLES, default 4: cycles the CPU is held in reset after a load session ends.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth for the load_sw input.
REQ-003 Reset rst is asynchronous and active-high; clock clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 load_sw  input  1  asynchronous board switch; high requests instruction-load mode.
REQ-007 w_ready_rx  input  1  one-cycle pulse from the UART word assembler: instr_data_rx and addr_rx are valid.
REQ-008 instr_data_rx  input  32  assembled instruction word.
REQ-009 addr_rx  input  32  assembled byte address.
REQ-010 cpu_req  input  1  CPU fetch enable.
REQ-011 cpu_addr  input  32  CPU fetch byte address.
REQ-012 pos_instr_w  output  1  one-cycle pulse that starts a UART assembler session.
REQ-013 neg_instr_w  output  1  one-cycle pulse that ends a UART assembler session.
REQ-014 mem_en, mem_we  output  1 each  instruction-memory enable and write strobe.
REQ-015 mem_addr, mem_wdata  output  32 each  instruction-memory address and write data.
REQ-016 cpu_stall  output  1  freezes CPU fetch.
REQ-017 cpu_hold_rst  output  1  holds the CPU in reset.
REQ-018 load_active  output  1  high in the LOAD and WRITE states.
REQ-019 word_cnt  output  16  count of words written in the current session.
REQ-020 err_misaligned  output  1  sticky flag: a received address had addr_rx[1:0] != 0.

Function
REQ-021 load_sw shall pass through a SYNC_STAGES flop synchroniser plus one history flop; rise and fall are detected on the synchronised signal.
REQ-022 FSM states: RUN, LOAD, WRITE, HOLD.
REQ-023 RUN: mem_en=cpu_req, mem_we=0, mem_addr=cpu_addr, cpu_stall=0, cpu_hold_rst=0; a sync rise pulses pos_instr_w in the same cycle, clears word_cnt and err_misaligned, and moves to LOAD.
REQ-024 LOAD: cpu_stall=1, cpu_hold_rst=1, mem_en=0; a w_ready_rx pulse latches addr_rx and instr_data_rx and moves to WRITE.
REQ-025 LOAD, sync fall with no w_ready_rx: pulse neg_instr_w, load the release counter with RELEASE_CYCLES, move to HOLD.
REQ-026 WRITE (exactly 1 cycle): mem_en=1, mem_we=1, mem_addr=latched addr with bits [1:0] forced to 0, mem_wdata=latched data; word_cnt+1, saturating at 0xFFFF; return to LOAD.
REQ-027 In WRITE, if latched addr[1:0] != 0, err_misaligned shall set and the write shall still occur at the aligned address.
REQ-028 Simultaneous sync fall and w_ready_rx in LOAD: take WRITE first, latch a pending-fall bit; the next LOAD cycle executes REQ-025 and clears the bit.
REQ-029 A sync fall during WRITE shall set the pending-fall bit.
REQ-030 A w_ready_rx pulse in RUN or HOLD shall be ignored, with no memory write.
REQ-031 HOLD: cpu_stall=1, cpu_hold_rst=1, mem_en=0; the counter decrements each cycle; at 0, move to RUN (CPU released the next cycle).
REQ-032 A sync rise in HOLD shall pulse pos_instr_w, clear word_cnt and err_misaligned, and return to LOAD.
REQ-033 pos_instr_w and neg_instr_w are never high in the same cycle, and each lasts exactly 1 cycle.
REQ-034 The latency from a w_ready_rx pulse to mem_we is exactly 1 cycle.
REQ-035 The minimum supported interval between w_ready_rx pulses is 2 cycles.

Reset
REQ-036 On rst: state RUN; synchroniser flops, history flop, pending-fall bit and counter at 0; all outputs 0 except mem_en/mem_addr, which follow cpu_req/cpu_addr combinationally.
REQ-037 An rst asserted mid-session shall abandon the session with no neg_instr_w pulse and no further write; after rst deasserts, a still-high load_sw shall not produce a rise.

Verification
REQ-038 load_sw 0->1 -> pos_instr_w pulse SYNC_STAGES+1 cycles later; cpu_stall=1, cpu_hold_rst=1, load_active=1.
REQ-039 In LOAD, w_ready_rx with addr_rx=0x10, data=0x00500093 -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0x00500093; word_cnt=1.
REQ-040 addr_rx=0x13 -> write at 0x10; err_misaligned=1 until the next pos_instr_w.
REQ-041 Synchronised fall coincident with w_ready_rx -> write occurs, then neg_instr_w, then 4 cycles of HOLD; cpu_hold_rst falls exactly 5 cycles after neg_instr_w.
REQ-042 w_ready_rx in RUN with cpu_req=1, cpu_addr=0x40 -> mem_we stays 0, mem_addr=0x40.
REQ-043 rst pulsed during LOAD -> state RUN; all outputs reset; no neg_instr_w pulse.
